// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between icache (0) and dcache (1); one cycle to arbitrate, grant held from AR to the last R beat.
// Back-pressure passes straight through; ARB_ROUND_ROBIN_EN selects round-robin, otherwise dcache has fixed priority.
module axi_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_arvalid,
  input  logic [ADDR_W-1:0] ic_araddr,
  input  logic [7:0]        ic_arlen,
  input  logic [2:0]        ic_arsize,
  output logic              ic_arready,
  output logic              ic_rvalid,
  output logic              ic_rlast,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              ic_rready,
  input  logic              dc_arvalid,
  input  logic [ADDR_W-1:0] dc_araddr,
  input  logic [7:0]        dc_arlen,
  input  logic [2:0]        dc_arsize,
  output logic              dc_arready,
  output logic              dc_rvalid,
  output logic              dc_rlast,
  output logic [DATA_W-1:0] dc_rdata,
  input  logic              dc_rready,
  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  input  logic [DATA_W-1:0] m_axi_rdata,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              grant_id,
  output logic              burst_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic       pick;
  logic       req_any;
  logic       rready_sel;
  logic       r_hs;
  logic       burst_done;

  assign req_any    = ic_arvalid | dc_arvalid;
  assign rready_sel = grant_id ? dc_rready : ic_rready;
  assign r_hs       = (state == DATA) && m_axi_rvalid && rready_sel;
  assign burst_done = r_hs && m_axi_rlast;
  assign busy       = (state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Pointer only matters on a tie; a lone requester always wins.
  always_comb pick = (ic_arvalid && dc_arvalid) ? rr_ptr : dc_arvalid;

  always_ff @(posedge clk) begin
    if (reset)           rr_ptr <= 1'b0;
    else if (burst_done) rr_ptr <= ~rr_ptr;
  end
`else
  always_comb pick = dc_arvalid;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_rready  = 1'b0;
    ic_arready    = 1'b0;
    dc_arready    = 1'b0;
    ic_rvalid     = 1'b0;
    ic_rlast      = 1'b0;
    ic_rdata      = '0;
    dc_rvalid     = 1'b0;
    dc_rlast      = 1'b0;
    dc_rdata      = '0;
    case (state)
      IDLE: begin
        if (req_any) state_nxt = ADDR;
      end
      ADDR: begin
        m_axi_arvalid = grant_id ? dc_arvalid : ic_arvalid;
        m_axi_araddr  = grant_id ? dc_araddr  : ic_araddr;
        m_axi_arlen   = grant_id ? dc_arlen   : ic_arlen;
        m_axi_arsize  = grant_id ? dc_arsize  : ic_arsize;
        ic_arready    = !grant_id && m_axi_arready;
        dc_arready    = grant_id && m_axi_arready;
        if (m_axi_arvalid && m_axi_arready) state_nxt = DATA;
      end
      DATA: begin
        m_axi_rready = rready_sel;
        ic_rvalid    = !grant_id && m_axi_rvalid;
        ic_rlast     = !grant_id && m_axi_rlast;
        dc_rvalid    = grant_id && m_axi_rvalid;
        dc_rlast     = grant_id && m_axi_rlast;
        ic_rdata     = m_axi_rdata;
        dc_rdata     = m_axi_rdata;
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id  <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      // beat_cnt holds beats already accepted, so the final beat sees beat_cnt == arlen.
      burst_err <= r_hs && (m_axi_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q));
      if (state == IDLE && req_any) begin
        grant_id <= pick;
        len_q    <= pick ? dc_arlen : ic_arlen;
      end
      if (r_hs) beat_cnt <= m_axi_rlast ? 8'd0 : beat_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: AR and R expectations are queued as stimulus is driven
// and popped by a negedge monitor on each handshake.
module tb_axi_read_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_arvalid, dc_arvalid;
  logic [AW-1:0] ic_araddr, dc_araddr;
  logic [7:0]    ic_arlen, dc_arlen;
  logic [2:0]    ic_arsize, dc_arsize;
  logic          ic_arready, dc_arready;
  logic          ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
  logic [DW-1:0] ic_rdata, dc_rdata;
  logic          ic_rready, dc_rready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic          m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          busy, grant_id, burst_err;

  axi_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arsize(ic_arsize),
    .ic_arready(ic_arready), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rdata(ic_rdata),
    .ic_rready(ic_rready),
    .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen), .dc_arsize(dc_arsize),
    .dc_arready(dc_arready), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast), .dc_rdata(dc_rdata),
    .dc_rready(dc_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready),
    .busy(busy), .grant_id(grant_id), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic id; logic [DW-1:0] data; logic last; } r_t;
  ar_t ar_q[$];
  r_t  r_q[$];
  ar_t ae;
  r_t  re;
  int  ic_beats = 0;
  int  dc_beats = 0;
  logic rr_model;

  always @(negedge clk) begin
    if (!reset && m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        ae = ar_q.pop_front();
        chk("ar_grant", grant_id, ae.id);
        chk("ar_addr", m_axi_araddr, ae.addr);
        chk("ar_len", m_axi_arlen, ae.len);
        chk("ar_size", m_axi_arsize, 3);
        chk("ar_rdy_route", ae.id ? {dc_arready, ic_arready} : {ic_arready, dc_arready}, 2'b10);
      end
    end
    if (!reset && m_axi_rvalid && m_axi_rready) begin
      if (r_q.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        re = r_q.pop_front();
        chk("r_grant", grant_id, re.id);
        chk("r_vld_route", re.id ? {dc_rvalid, ic_rvalid} : {ic_rvalid, dc_rvalid}, 2'b10);
        chk("r_data", re.id ? dc_rdata : ic_rdata, re.data);
        chk("r_last", re.id ? dc_rlast : ic_rlast, re.last);
        if (re.id) dc_beats++; else ic_beats++;
      end
    end
  end

  task automatic req(input bit id, input logic [AW-1:0] addr, input logic [7:0] len);
    if (id) begin dc_arvalid = 1; dc_araddr = addr; dc_arlen = len; dc_arsize = 3; end
    else    begin ic_arvalid = 1; ic_araddr = addr; ic_arlen = len; ic_arsize = 3; end
  endtask

  task automatic expect_ar(input bit id, input logic [AW-1:0] addr, input logic [7:0] len);
    ar_q.push_back('{id: id, addr: addr, len: len});
  endtask

  task automatic drive_beat(input bit g, input bit last);
    m_axi_rvalid = 1;
    m_axi_rdata  = {$urandom, $urandom};
    m_axi_rlast  = last;
    r_q.push_back('{id: g, data: m_axi_rdata, last: last});
  endtask

  // Plays the shared slave for one burst; rlast goes out on beat last_beat.
  task automatic serve(input int ar_dly, input int last_beat, input bit toggle,
                       input int abort_after, input bit exp_err);
    int k; bit g; bit hs; int b; bit done;
    k = 0;
    @(negedge clk);
    while (!m_axi_arvalid && k < 50) begin @(negedge clk); k++; end
    if (!m_axi_arvalid) begin chk("ar_timeout", 0, 1); return; end
    repeat (ar_dly) @(negedge clk);
    chk("ar_held", m_axi_arvalid, 1);
    @(posedge clk); #1 m_axi_arready = 1;
    @(negedge clk); g = dc_arready;
    @(posedge clk); #1 m_axi_arready = 0;
    if (g) begin dc_arvalid = 0; dc_rready = 1; end
    else   begin ic_arvalid = 0; ic_rready = 1; end
    b = 1; done = 0; k = 0;
    drive_beat(g, b == last_beat);
    while (k < 200 && !done) begin
      @(negedge clk); k++;
      hs = m_axi_rvalid && m_axi_rready;
      chk("rready_mirror", m_axi_rready, g ? dc_rready : ic_rready);
      chk("hold_off", {ic_arready, dc_arready}, 0);
      chk("busy_data", busy, 1);
      @(posedge clk); #1;
      if (toggle) begin
        if (g) dc_rready = ~dc_rready; else ic_rready = ~ic_rready;
      end
      if (hs && b == abort_after) begin
        m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant_id, 0);
        chk("abort_err", burst_err, 0);
        chk("abort_vld_rdy", {m_axi_arvalid, m_axi_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid}, 0);
        rr_model = 0;
        r_q.delete();
        return;
      end
      if (hs) begin
        if (b == last_beat) begin
          m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
          rr_model = ~rr_model;
          done = 1;
        end else begin
          b++;
          drive_beat(g, b == last_beat);
        end
      end
    end
    if (!done) begin chk("r_timeout", 0, 1); return; end
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("burst_err", burst_err, exp_err);
    chk("arvalid_bubble", m_axi_arvalid, 0);
    if (exp_err) begin
      @(negedge clk);
      chk("err_pulse_end", burst_err, 0);
    end
  endtask

  initial begin
    int base;
    bit w;
    reset = 1;
    {ic_arvalid, dc_arvalid, ic_rready, dc_rready} = '0;
    {ic_araddr, dc_araddr, ic_arlen, dc_arlen, ic_arsize, dc_arsize} = '0;
    {m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
    m_axi_rdata = '0;
    rr_model = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_outs", {m_axi_arvalid, m_axi_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}, 0);
    chk("rst_addr", m_axi_araddr, 0);
    chk("rst_rdata", ic_rdata | dc_rdata, 0);

    // Single icache burst, one-cycle arbitration latency
    @(posedge clk); #1;
    req(0, 64'h1000, 8'd7); expect_ar(0, 64'h1000, 8'd7);
    @(negedge clk);
    chk("arb_cycle_arvalid", m_axi_arvalid, 0);
    chk("arb_cycle_busy", busy, 0);
    base = ic_beats;
    serve(2, 8, 0, 0, 0);
    chk("ic_beats", ic_beats - base, 8);

    // Simultaneous requests, three rounds
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      req(0, 64'h2000 + 64'(r * 'h100), 8'd3);
      req(1, 64'h8000 + 64'(r * 'h100), 8'd3);
`ifdef ARB_ROUND_ROBIN_EN
      w = rr_model;
`else
      w = 1'b1;
`endif
      expect_ar(w, w ? 64'h8000 + 64'(r * 'h100) : 64'h2000 + 64'(r * 'h100), 8'd3);
      expect_ar(!w, w ? 64'h2000 + 64'(r * 'h100) : 64'h8000 + 64'(r * 'h100), 8'd3);
      serve(0, 4, 0, 0, 0);
      serve(0, 4, 0, 0, 0);
    end

    // R backpressure on dcache
    @(posedge clk); #1;
    req(1, 64'h9000, 8'd3); expect_ar(1, 64'h9000, 8'd3);
    base = dc_beats;
    serve(1, 4, 1, 0, 0);
    chk("dc_beats_bp", dc_beats - base, 4);

    // Early rlast: arlen=3, rlast on beat 2
    @(posedge clk); #1;
    req(0, 64'h3000, 8'd3); expect_ar(0, 64'h3000, 8'd3);
    serve(0, 2, 0, 0, 1);

    // Reset after beat 2 of 8, then a normal burst
    @(posedge clk); #1;
    req(0, 64'h4000, 8'd7); expect_ar(0, 64'h4000, 8'd7);
    serve(0, 8, 0, 2, 0);
    @(posedge clk); #1;
    req(0, 64'h5000, 8'd1); expect_ar(0, 64'h5000, 8'd1);
    base = ic_beats;
    serve(0, 2, 0, 0, 0);
    chk("ic_beats_post_rst", ic_beats - base, 2);
    chk("ar_q_empty", ar_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
